amo_queue: RTL

Parametrised multi-entry atomic-memory-operation queue for the load/store unit. It captures AMOs issued speculatively from the LSU and holds each until the commit stage releases it and the store buffer drains. It issues the head entry to the data cache with a ready/valid handshake and returns the sign-adjusted result to writeback. It generalises the single-slot AMO buffer with configurable depth and widths, a head-entry state machine, a flush that preserves the committed head, and an optional response watchdog.

---
 rtl/amo_queue_if.sv | 48 ++++
 rtl/amo_queue.sv | 153 +++++++++++++++
 2 files changed

// File: rtl/amo_queue_if.sv
// Handshake bundle between the LSU/commit/cache side and the AMO queue.
interface amo_queue_if #(
  parameter int XLEN  = 32,
  parameter int PLEN  = 34,
  parameter int DEPTH = 2
);
  localparam int UW = $clog2(DEPTH + 1);

  logic            flush_i;
  logic            valid_i;
  logic            ready_o;
  logic [3:0]      amo_op_i;
  logic [PLEN-1:0] paddr_i;
  logic [XLEN-1:0] data_i;
  logic [1:0]      data_size_i;
  logic            amo_valid_commit_i;
  logic            no_st_pending_i;
  logic            amo_req_valid_o;
  logic            amo_req_ready_i;
  logic [3:0]      amo_req_op_o;
  logic [1:0]      amo_req_size_o;
  logic [63:0]     amo_req_addr_o;
  logic [63:0]     amo_req_data_o;
  logic            amo_resp_valid_i;
  logic [63:0]     amo_resp_result_i;
  logic            result_valid_o;
  logic [XLEN-1:0] result_o;
  logic [UW-1:0]   usage_o;
  logic            timeout_o;

  modport slave (
    input  flush_i, valid_i, amo_op_i, paddr_i, data_i, data_size_i,
    input  amo_valid_commit_i, no_st_pending_i, amo_req_ready_i,
    input  amo_resp_valid_i, amo_resp_result_i,
    output ready_o, amo_req_valid_o, amo_req_op_o, amo_req_size_o,
    output amo_req_addr_o, amo_req_data_o, result_valid_o, result_o,
    output usage_o, timeout_o
  );

  modport master (
    output flush_i, valid_i, amo_op_i, paddr_i, data_i, data_size_i,
    output amo_valid_commit_i, no_st_pending_i, amo_req_ready_i,
    output amo_resp_valid_i, amo_resp_result_i,
    input  ready_o, amo_req_valid_o, amo_req_op_o, amo_req_size_o,
    input  amo_req_addr_o, amo_req_data_o, result_valid_o, result_o,
    input  usage_o, timeout_o
  );
endinterface

// File: rtl/amo_queue.sv
// Multi-entry AMO queue: holds AMOs until commit, issues head to D$.
// Optional response watchdog enabled by AMO_QUEUE_WATCHDOG_EN.
module amo_queue #(
  parameter int XLEN    = 32,
  parameter int PLEN    = 34,
  parameter int DEPTH   = 2,
  parameter int TIMEOUT = 1024
) (
  input  logic       clk_i,
  input  logic       rst_i,
  amo_queue_if.slave bus
);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int UW = $clog2(DEPTH + 1);

  typedef enum logic [1:0] {
    IDLE, WAIT_COMMIT, REQ, WAIT_RESP
  } state_t;

  state_t          state_q, state_n;
  logic            committed_q, committed_n;
  logic [PW-1:0]   rptr_q, rptr_n, wptr_q, wptr_n;
  logic [UW-1:0]   usage_q, usage_n;
  logic [3:0]      op_q   [DEPTH];
  logic [PLEN-1:0] addr_q [DEPTH];
  logic [XLEN-1:0] data_q [DEPTH];
  logic [1:0]      size_q [DEPTH];
  logic            res_valid_q, tmo_q;
  logic [XLEN-1:0] res_q, res_d;
  logic [63:0]     raw;
  logic            push, pop, resp, tmo, commit_now, go, head_kept;

  function automatic logic [PW-1:0] inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign bus.ready_o = usage_q < UW'(DEPTH);
  assign push = bus.valid_i && bus.ready_o && !bus.flush_i;
  assign resp = (state_q == WAIT_RESP) && bus.amo_resp_valid_i;
  assign pop  = resp || tmo;
  assign commit_now = (state_q == WAIT_COMMIT) && bus.amo_valid_commit_i
                      && !committed_q;
  assign go = (state_q == WAIT_COMMIT) && bus.no_st_pending_i
              && (committed_q || bus.amo_valid_commit_i);
  // A commit in the flush cycle still protects the head.
  assign head_kept = !pop && (committed_q || commit_now
                     || state_q == REQ || state_q == WAIT_RESP);

`ifdef AMO_QUEUE_WATCHDOG_EN
  localparam int CW = $clog2(TIMEOUT + 1);
  logic [CW-1:0] wd_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) wd_q <= '0;
    else if (state_q == WAIT_RESP && !pop) wd_q <= wd_q + CW'(1);
    else wd_q <= '0;
  end

  assign tmo = (state_q == WAIT_RESP) && !bus.amo_resp_valid_i
               && (wd_q == CW'(TIMEOUT - 1));
`else
  assign tmo = 1'b0;
`endif

  always_comb begin
    state_n     = state_q;
    committed_n = committed_q;
    rptr_n      = rptr_q;
    wptr_n      = wptr_q;
    usage_n     = usage_q;
    if (pop) rptr_n = inc(rptr_q);
    if (bus.flush_i) begin
      if (head_kept) begin
        wptr_n  = inc(rptr_q);
        usage_n = UW'(1);
      end else begin
        wptr_n  = rptr_n;
        usage_n = '0;
      end
    end else begin
      if (push) wptr_n = inc(wptr_q);
      usage_n = usage_q + UW'(push) - UW'(pop);
    end
    unique case (state_q)
      IDLE: if (push) state_n = WAIT_COMMIT;
      WAIT_COMMIT: begin
        if (go) begin
          state_n     = REQ;
          committed_n = 1'b0;
        end else if (commit_now) begin
          committed_n = 1'b1;
        end
      end
      REQ: if (bus.amo_req_ready_i) state_n = WAIT_RESP;
      WAIT_RESP: begin
        if (pop) state_n = (usage_n != '0) ? WAIT_COMMIT : IDLE;
      end
      default: state_n = IDLE;
    endcase
    if (bus.flush_i && !head_kept) begin
      state_n     = IDLE;
      committed_n = 1'b0;
    end
  end

  always_comb begin
    raw   = resp ? bus.amo_resp_result_i : '1;
    res_d = raw[XLEN-1:0];
    if (XLEN == 64 && size_q[rptr_q] == 2'b10)
      res_d = XLEN'($signed(raw[31:0]));
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      committed_q <= 1'b0;
      rptr_q      <= '0;
      wptr_q      <= '0;
      usage_q     <= '0;
      res_valid_q <= 1'b0;
      res_q       <= '0;
      tmo_q       <= 1'b0;
    end else begin
      state_q     <= state_n;
      committed_q <= committed_n;
      rptr_q      <= rptr_n;
      wptr_q      <= wptr_n;
      usage_q     <= usage_n;
      res_valid_q <= pop;
      tmo_q       <= tmo;
      if (pop) res_q <= res_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push) begin
      op_q[wptr_q]   <= bus.amo_op_i;
      addr_q[wptr_q] <= bus.paddr_i;
      data_q[wptr_q] <= bus.data_i;
      size_q[wptr_q] <= bus.data_size_i;
    end
  end

  assign bus.amo_req_valid_o = (state_q == REQ);
  assign bus.amo_req_op_o    = op_q[rptr_q];
  assign bus.amo_req_size_o  = size_q[rptr_q];
  assign bus.amo_req_addr_o  = 64'(addr_q[rptr_q]);
  assign bus.amo_req_data_o  = 64'(data_q[rptr_q]);
  assign bus.result_valid_o  = res_valid_q;
  assign bus.result_o        = res_q;
  assign bus.usage_o         = usage_q;
  assign bus.timeout_o       = tmo_q;
endmodule
